game_flow_controller: RTL and testbench

Top-level sequencer for the two-player arrow game. Walks the game through idle, player ready-up, a 3-2-1 countdown, timed play, and a result hold. Drives the enables for the pattern generator, game timer, score tracker and music, and decides the winner from the two final scores. Sits between the debounced player inputs and the timer, pattern, score and music blocks.

---
 rtl/game_flow_controller.sv | 201 ++++++++++++++++++++
 tb/tb_game_flow_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// Top-level sequencer for the two-player arrow game: idle, ready-up, countdown,
// timed play, one-cycle finish and result hold, with winner decision.
`timescale 1ns/1ps
module game_flow_controller #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned COUNT_SECS = 3,
  parameter int unsigned SCORE_W    = 7
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start_req,
  input  logic [3:0]         player_a_keys,
  input  logic [3:0]         player_b_keys,
  input  logic               game_over,
  input  logic [SCORE_W-1:0] score_a,
  input  logic [SCORE_W-1:0] score_b,
  output logic               game_active,
  output logic               timer_start,
  output logic               clear_scores,
  output logic               music_en,
  output logic [1:0]         countdown_val,
  output logic               ready_a,
  output logic               ready_b,
  output logic [2:0]         state,
  output logic [1:0]         winner
);

  localparam int unsigned      TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [1:0]       CD_START  = 2'(COUNT_SECS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READY     = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_PLAY      = 3'd3,
    S_FINISH    = 3'd4,
    S_RESULT    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                armed_q, armed_d;
  logic                start_prev_q;
  logic [3:0]          keys_a_prev_q, keys_b_prev_q;

  logic                game_active_d, timer_start_d, clear_scores_d, music_en_d;
  logic [1:0]          countdown_d, winner_d;
  logic                ready_a_d, ready_b_d;

  logic                start_edge, key_edge_a, key_edge_b;

  assign start_edge = start_req & ~start_prev_q;
  assign key_edge_a = |(player_a_keys & ~keys_a_prev_q);
  assign key_edge_b = |(player_b_keys & ~keys_b_prev_q);
  assign state      = state_q;

  // Next-state and next-output decode; pulses default low, levels default held.
  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    armed_d        = armed_q;
    game_active_d  = game_active;
    timer_start_d  = 1'b0;
    clear_scores_d = 1'b0;
    music_en_d     = music_en;
    countdown_d    = countdown_val;
    ready_a_d      = ready_a;
    ready_b_d      = ready_b;
    winner_d       = winner;

    case (state_q)
      S_IDLE: begin
        game_active_d = 1'b0;
        music_en_d    = 1'b0;
        countdown_d   = 2'd0;
        ready_a_d     = 1'b0;
        ready_b_d     = 1'b0;
        winner_d      = 2'b00;
        tick_d        = '0;
        armed_d       = 1'b0;
        if (start_edge) begin
          state_d        = S_READY;
          clear_scores_d = 1'b1;
        end
      end

      S_READY: begin
        // Cancel takes priority over both players having readied.
        if (start_edge) begin
          state_d   = S_IDLE;
          ready_a_d = 1'b0;
          ready_b_d = 1'b0;
        end else if (ready_a && ready_b) begin
          state_d     = S_COUNTDOWN;
          countdown_d = CD_START;
          tick_d      = '0;
        end else begin
          ready_a_d = ready_a | key_edge_a;
          ready_b_d = ready_b | key_edge_b;
        end
      end

      S_COUNTDOWN: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (countdown_val > 2'd1) begin
            countdown_d = countdown_val - 2'd1;
          end else begin
            state_d       = S_PLAY;
            timer_start_d = 1'b1;
            game_active_d = 1'b1;
            music_en_d    = 1'b1;
            countdown_d   = 2'd0;
            armed_d       = 1'b0;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      S_PLAY: begin
        // game_over only counts after it has been seen low this round.
        if (game_over && armed_q) begin
          state_d       = S_FINISH;
          game_active_d = 1'b0;
          music_en_d    = 1'b0;
          if (score_a > score_b)      winner_d = 2'b01;
          else if (score_b > score_a) winner_d = 2'b10;
          else                        winner_d = 2'b11;
        end else if (!game_over) begin
          armed_d = 1'b1;
        end
      end

      S_FINISH: begin
        state_d   = S_RESULT;
        ready_a_d = 1'b0;
        ready_b_d = 1'b0;
      end

      S_RESULT: begin
        ready_a_d = 1'b0;
        ready_b_d = 1'b0;
        if (start_edge) begin
          state_d        = S_READY;
          clear_scores_d = 1'b1;
          winner_d       = 2'b00;
        end
      end

      default: begin
        state_d       = S_IDLE;
        game_active_d = 1'b0;
        music_en_d    = 1'b0;
        countdown_d   = 2'd0;
        ready_a_d     = 1'b0;
        ready_b_d     = 1'b0;
        winner_d      = 2'b00;
        tick_d        = '0;
        armed_d       = 1'b0;
      end
    endcase
  end

  // State, outputs and edge-detect history.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      tick_q        <= '0;
      armed_q       <= 1'b0;
      start_prev_q  <= 1'b0;
      keys_a_prev_q <= 4'd0;
      keys_b_prev_q <= 4'd0;
      game_active   <= 1'b0;
      timer_start   <= 1'b0;
      clear_scores  <= 1'b0;
      music_en      <= 1'b0;
      countdown_val <= 2'd0;
      ready_a       <= 1'b0;
      ready_b       <= 1'b0;
      winner        <= 2'b00;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      armed_q       <= armed_d;
      start_prev_q  <= start_req;
      keys_a_prev_q <= player_a_keys;
      keys_b_prev_q <= player_b_keys;
      game_active   <= game_active_d;
      timer_start   <= timer_start_d;
      clear_scores  <= clear_scores_d;
      music_en      <= music_en_d;
      countdown_val <= countdown_d;
      ready_a       <= ready_a_d;
      ready_b       <= ready_b_d;
      winner        <= winner_d;
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed vector table, hand-written corner
// sequences and random stimulus, all checked against a cycle-level game model.
`timescale 1ns/1ps
module tb_game_flow_controller;

  localparam int unsigned TICK = 4;
  localparam int unsigned SECS = 3;
  localparam int unsigned SW   = 7;

  logic          clk;
  logic          reset;
  logic          start_req;
  logic [3:0]    player_a_keys, player_b_keys;
  logic          game_over;
  logic [SW-1:0] score_a, score_b;
  logic          game_active, timer_start, clear_scores, music_en;
  logic [1:0]    countdown_val, winner;
  logic          ready_a, ready_b;
  logic [2:0]    state;

  game_flow_controller #(.TICK_DIV(TICK), .COUNT_SECS(SECS), .SCORE_W(SW)) dut (
    .CLOCK_50(clk), .reset(reset), .start_req(start_req),
    .player_a_keys(player_a_keys), .player_b_keys(player_b_keys),
    .game_over(game_over), .score_a(score_a), .score_b(score_b),
    .game_active(game_active), .timer_start(timer_start),
    .clear_scores(clear_scores), .music_en(music_en),
    .countdown_val(countdown_val), .ready_a(ready_a), .ready_b(ready_b),
    .state(state), .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] dut_vec;
  assign dut_vec = {state, game_active, timer_start, clear_scores, music_en,
                    countdown_val, ready_a, ready_b, winner};

  int n_cmp = 0;
  int n_err = 0;

  // Game model: phase number, remaining countdown cycles, flags and history.
  int         m_st, m_cd_left;
  bit         m_armed, m_ra, m_rb, m_ts, m_cs, m_pstart;
  logic [3:0] m_pa, m_pb;
  logic [1:0] m_w;

  task automatic model_reset();
    m_st = 0; m_cd_left = 0; m_armed = 0; m_ra = 0; m_rb = 0;
    m_ts = 0; m_cs = 0; m_pstart = 0; m_pa = 4'd0; m_pb = 4'd0; m_w = 2'b00;
  endtask

  task automatic model_step();
    bit se, ea, eb;
    if (!reset) begin
      model_reset();
    end else begin
      se = start_req && !m_pstart;
      ea = |(player_a_keys & ~m_pa);
      eb = |(player_b_keys & ~m_pb);
      m_ts = 0; m_cs = 0;
      case (m_st)
        0: if (se) begin m_st = 1; m_cs = 1; end
        1: if (se) begin m_st = 0; m_ra = 0; m_rb = 0; end
           else if (m_ra && m_rb) begin m_st = 2; m_cd_left = SECS * TICK; end
           else begin m_ra = m_ra | ea; m_rb = m_rb | eb; end
        2: begin
             m_cd_left = m_cd_left - 1;
             if (m_cd_left == 0) begin m_st = 3; m_ts = 1; m_armed = 0; end
           end
        3: if (game_over && m_armed) begin
             m_st = 4;
             m_w = (score_a > score_b) ? 2'b01 : (score_b > score_a) ? 2'b10 : 2'b11;
           end else if (!game_over) m_armed = 1;
        4: begin m_st = 5; m_ra = 0; m_rb = 0; end
        5: if (se) begin m_st = 1; m_cs = 1; m_w = 2'b00; end
        default: m_st = 0;
      endcase
      m_pstart = start_req;
      m_pa = player_a_keys;
      m_pb = player_b_keys;
    end
  endtask

  function automatic logic [12:0] model_vec();
    logic [1:0] cd;
    cd = (m_st == 2) ? 2'((m_cd_left + int'(TICK) - 1) / int'(TICK)) : 2'd0;
    return {3'(m_st), m_st == 3, m_ts, m_cs, m_st == 3, cd, m_ra, m_rb, m_w};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model at the edge, compare at the following negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", 16'(dut_vec), 16'(model_vec()));
  endtask

  task automatic drive(input logic s, input logic [3:0] a, input logic [3:0] b, input logic g);
    start_req = s; player_a_keys = a; player_b_keys = b; game_over = g;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (state !== s && n < budget) begin cycle(); n++; end
    check(name, 16'(state), 16'(s));
  endtask

  task automatic ready_up();
    player_a_keys = 4'b0001; cycle();
    player_a_keys = 4'b0000; player_b_keys = 4'b0010; cycle();
    player_b_keys = 4'b0000; cycle();
    check("enter_cd", 16'({state, countdown_val}), 16'({3'd2, 2'd3}));
  endtask

  task automatic async_reset(input string name);
    #2 reset = 1'b0;
    #1 check(name, 16'(dut_vec), 16'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // From RESULT: restart, ready up with a stale game_over, then finish the round.
  task automatic play_round(input logic [SW-1:0] sa, input logic [SW-1:0] sb, input logic [1:0] expw);
    score_a = sa; score_b = sb;
    start_req = 1'b1; cycle();
    check("restart", 16'({state, winner, clear_scores}), 16'({3'd1, 2'b00, 1'b1}));
    start_req = 1'b0; cycle();
    check("clr_once", 16'(clear_scores), 16'd0);
    game_over = 1'b1;
    ready_up();
    wait_state(3'd3, 20, "to_play");
    check("ts_pulse", 16'({timer_start, game_active, music_en}), 16'(3'b111));
    repeat (3) cycle();
    check("stale_go", 16'({state, game_active, timer_start}), 16'({3'd3, 1'b1, 1'b0}));
    game_over = 1'b0; cycle();
    game_over = 1'b1; cycle();
    check("finish", 16'({state, game_active, music_en}), 16'({3'd4, 1'b0, 1'b0}));
    cycle();
    check("result", 16'({state, winner, ready_a, ready_b}), 16'({3'd5, expw, 1'b0, 1'b0}));
  endtask

  typedef struct {
    logic       start;
    logic [3:0] ka, kb;
    logic       go;
    logic [2:0] st;
    logic       cs, ts, ga;
    logic [1:0] cd;
    logic       ra, rb;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Start, ready-up with a five-cycle gap, full countdown, entry to play.
    tbl[0] = '{1'b1, 4'd0, 4'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'd0, 4'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 4'd1, 4'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    for (int i = 3; i <= 6; i++)
      tbl[i] = '{1'b0, 4'd0, 4'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 4'd0, 4'd4, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1};
    for (int k = 0; k < 12; k++)
      tbl[8+k] = '{1'b0, 4'd0, 4'd0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 2'(3 - k / 4), 1'b1, 1'b1};
    tbl[20] = '{1'b0, 4'd0, 4'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[21] = '{1'b0, 4'd0, 4'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1};

    reset = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    score_a = '0; score_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset", 16'(dut_vec), 16'd0);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].start, tbl[i].ka, tbl[i].kb, tbl[i].go);
      cycle();
      check($sformatf("tbl%0d", i),
            16'({state, clear_scores, timer_start, game_active, countdown_val, ready_a, ready_b}),
            16'({tbl[i].st, tbl[i].cs, tbl[i].ts, tbl[i].ga, tbl[i].cd, tbl[i].ra, tbl[i].rb}));
    end

    // Armed play round finishing with A ahead.
    score_a = 7'd42; score_b = 7'd17; game_over = 1'b1; cycle();
    check("finish_a", 16'({state, game_active, music_en}), 16'({3'd4, 1'b0, 1'b0}));
    cycle();
    check("win_a", 16'({state, winner}), 16'({3'd5, 2'b01}));

    play_round(7'd9, 7'd9, 2'b11);
    play_round(7'd0, 7'd99, 2'b10);

    // Key held across READY entry does not count; cancel from READY.
    game_over = 1'b0;
    player_a_keys = 4'b1000; start_req = 1'b1; cycle();
    check("ready_entry", 16'({state, winner}), 16'({3'd1, 2'b00}));
    start_req = 1'b0;
    repeat (3) cycle();
    check("held_key", 16'(ready_a), 16'd0);
    player_a_keys = 4'b0000; cycle();
    check("release", 16'(ready_a), 16'd0);
    player_a_keys = 4'b1000; cycle();
    check("repress", 16'({ready_a, ready_b}), 16'(2'b10));
    start_req = 1'b1; cycle();
    check("cancel", 16'({state, ready_a, ready_b}), 16'({3'd0, 1'b0, 1'b0}));
    start_req = 1'b0; player_a_keys = 4'b0000; cycle();

    // Asynchronous reset mid-countdown and mid-play.
    start_req = 1'b1; cycle(); start_req = 1'b0; cycle();
    ready_up();
    repeat (5) cycle();
    async_reset("rst_cd");
    repeat (5) cycle();
    check("idle_after_rst", 16'(state), 16'd0);
    start_req = 1'b1; cycle(); start_req = 1'b0; cycle();
    ready_up();
    wait_state(3'd3, 20, "to_play2");
    repeat (2) cycle();
    async_reset("rst_play");
    repeat (3) cycle();
    check("idle_after_rst2", 16'({state, game_active}), 16'd0);

    // Random stimulus against the model, with occasional resets.
    for (int it = 0; it < 4000; it++) begin
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 699) == 0) reset = 1'b0;
      if ($urandom_range(0, 24) == 0) start_req = ~start_req;
      if ($urandom_range(0, 5) == 0) player_a_keys = 4'($urandom);
      if ($urandom_range(0, 5) == 0) player_b_keys = 4'($urandom);
      if ($urandom_range(0, 7) == 0) game_over = ~game_over;
      score_a = SW'($urandom_range(0, 99));
      score_b = SW'($urandom_range(0, 99));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
